// File: rtl/perf_counter_bank.sv
// Bank of independent up/down event counters with sticky overflow, terminal-count pulses and a
// registered read port. Define PERF_CNT_SAT_EN to make counters saturate instead of wrapping.
module perf_counter_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CH    = 4,
    parameter int unsigned SEL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         i_en,
    input  logic [CH-1:0]         i_dir,
    input  logic                  i_clr_all,
    input  logic                  i_ld_we,
    input  logic [SEL_W-1:0]      i_ld_sel,
    input  logic [WIDTH-1:0]      i_ld_data,
    input  logic [SEL_W-1:0]      i_rd_sel,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic [CH*WIDTH-1:0]   o_q,
    output logic [CH-1:0]         o_ovf,
    output logic [CH-1:0]         o_tc
);

    logic [WIDTH-1:0] r_cnt [CH];
    logic [CH-1:0]    r_ovf;
    logic [CH-1:0]    r_tc;
    logic [WIDTH-1:0] r_rd_data;

    logic [WIDTH-1:0] w_cnt_d [CH];
    logic [CH-1:0]    w_ovf_d;
    logic [CH-1:0]    w_tc_d;
    logic [CH-1:0]    w_load_hit;
    logic [CH-1:0]    w_at_limit;
    logic [WIDTH-1:0] w_rd_d;

`ifdef PERF_CNT_SAT_EN
    // Set once a channel is pinned at its limit, so repeated steps there pulse tc only once.
    logic [CH-1:0]    r_pin;
    logic [CH-1:0]    w_pin_d;
`endif

    always_comb begin
        w_load_hit = '0;
        w_at_limit = '0;
        for (int i = 0; i < CH; i++) begin
            w_load_hit[i] = i_ld_we && (i_ld_sel == SEL_W'(i));
            w_at_limit[i] = i_dir[i] ? (r_cnt[i] == '0) : (r_cnt[i] == '1);
        end
    end

    always_comb begin
        w_ovf_d = r_ovf;
        w_tc_d  = '0;
`ifdef PERF_CNT_SAT_EN
        w_pin_d = r_pin;
`endif
        for (int i = 0; i < CH; i++) begin
            w_cnt_d[i] = r_cnt[i];
            if (i_clr_all) begin
                w_cnt_d[i] = '0;
                w_ovf_d[i] = 1'b0;
`ifdef PERF_CNT_SAT_EN
                w_pin_d[i] = 1'b0;
`endif
            end else if (w_load_hit[i]) begin
                w_cnt_d[i] = i_ld_data;
                w_ovf_d[i] = 1'b0;
`ifdef PERF_CNT_SAT_EN
                w_pin_d[i] = 1'b0;
`endif
            end else if (i_en[i]) begin
`ifdef PERF_CNT_SAT_EN
                if (w_at_limit[i]) begin
                    w_ovf_d[i] = 1'b1;
                    w_tc_d[i]  = !r_pin[i];
                    w_pin_d[i] = 1'b1;
                end else begin
                    w_cnt_d[i] = i_dir[i] ? r_cnt[i] - 1'b1 : r_cnt[i] + 1'b1;
                    w_pin_d[i] = 1'b0;
                end
`else
                w_cnt_d[i] = i_dir[i] ? r_cnt[i] - 1'b1 : r_cnt[i] + 1'b1;
                if (w_at_limit[i]) begin
                    w_ovf_d[i] = 1'b1;
                    w_tc_d[i]  = 1'b1;
                end
`endif
            end
        end
    end

    // Out-of-range selects match no channel and read back as zero.
    always_comb begin
        w_rd_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (i_rd_sel == SEL_W'(i)) begin
                w_rd_d = r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_ovf     <= '0;
            r_tc      <= '0;
            r_rd_data <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
            r_ovf     <= w_ovf_d;
            r_tc      <= w_tc_d;
            r_rd_data <= w_rd_d;
        end
    end

`ifdef PERF_CNT_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pin <= '0;
        end else begin
            r_pin <= w_pin_d;
        end
    end
`endif

    for (genvar g = 0; g < CH; g++) begin : g_q
        assign o_q[g*WIDTH +: WIDTH] = r_cnt[g];
    end

    assign o_ovf     = r_ovf;
    assign o_tc      = r_tc;
    assign o_rd_data = r_rd_data;

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised bank of independent up/down event counters for cycle, instruction and stall statistics in the single-cycle RISC-V CPU. Each channel can halt, count up, count down or be loaded, and keeps a sticky overflow flag. All counts are exposed on a flat bus and through a registered read port for the debug/display path.

## Interface

Parameters:
- `WIDTH`, 32: bit width of each counter.
- `CH`, 4: number of channels, 1..16.
- `SEL_W`, 4: width of the channel selects. Must satisfy 2^SEL_W ≥ CH.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in CH: per-channel count enable. Bit i drives channel i.
- `dir` in CH: per-channel direction. 0 = up, 1 = down.
- `clr_all` in 1: synchronous clear of every counter and overflow flag.
- `ld_we` in 1: load strobe.
- `ld_sel` in SEL_W: channel index for the load.
- `ld_data` in WIDTH: value to load.
- `rd_sel` in SEL_W: channel index for the read port.
- `rd_data` out WIDTH: registered count of channel `rd_sel`.
- `q` out CH*WIDTH: all counts, flat. Channel i occupies `q[i*WIDTH +: WIDTH]`.
- `ovf` out CH: sticky overflow/underflow flag per channel.
- `tc` out CH: one-cycle terminal-count pulse per channel.

## Operation

- Each channel's mode comes from `{load_hit, en}`, where `load_hit = ld_we && ld_sel == i`:
  - 00: halt.
  - 01: count in direction `dir`.
  - 10 or 11: load `ld_data`. Load beats counting.
- Per-channel priority: `clr_all` > load > count > hold.
- Up count: `cnt + 1`, modulo 2^WIDTH.
  - A step from all-ones sets `ovf[i]` and pulses `tc[i]`.
- Down count: `cnt - 1`.
  - A step from 0 sets `ovf[i]` and pulses `tc[i]`.
- `ovf[i]` is sticky. Only reset, `clr_all` or a load of channel i clear it.
- `tc[i]` is high only in the cycle after the wrapping edge and is never sticky.
- A load or clear never generates `tc`.
- `ld_sel` ≥ CH: the load is ignored; no channel changes.
- `rd_sel` ≥ CH: `rd_data` is 0 on the next edge.
- Channels are fully independent. Simultaneous events on different channels never interact.

## Timing

- Reset (async assert, `rst_n` = 0):
  - every counter = 0, `ovf` = 0, `tc` = 0, `rd_data` = 0, immediately.
  - Reset mid-count aborts all activity; there is no pending state.
- Deassertion is used synchronously. The first count occurs on the first rising edge with `rst_n` = 1.
- `q` is a direct view of the counter registers. A new value is visible right after the edge that caused it; this is 0 cycles of combinational latency.
- `rd_data` has 1-cycle latency: it samples `rd_sel` and the counter's *pre-edge* value.
  - Reading a channel that is changing on the same edge returns the old value.
- `ovf` and `tc` update on the same edge as the wrapping count.
- `clr_all` together with `ld_we`: the clear wins, and the loaded value is discarded.

## Configuration

- `PERF_CNT_SAT_EN` defined:
  - Counters saturate: up counting holds at all-ones, down counting holds at 0.
  - The first attempted step past the limit sets `ovf[i]` and pulses `tc[i]` once.
  - Further steps at the limit produce no new `tc`.
- Not defined: counters wrap modulo 2^WIDTH, and `tc` pulses on every wrap.

## Test plan

Bench configuration: `WIDTH` = 8, `CH` = 4.

- Reset/basic count: hold `rst_n` = 0, then release; assert `en` = 4'b0001, `dir` = 0 for 5 cycles.
  - Required: `q[7:0]` = 5, other channels stay 0, `ovf` = 0.
- Wrap (no macro): load ch1 with 8'hFE, then count up 3 cycles.
  - Required: ch1 = 8'h01.
  - `tc[1]` high exactly one cycle, after the FF→00 edge.
  - `ovf[1]` stays 1 until ch1 is loaded again.
- Saturate (`PERF_CNT_SAT_EN`): load ch2 with 8'h01, then count down 4 cycles.
  - Required: ch2 = 0, `ovf[2]` = 1, `tc[2]` pulsed once only.
- Priority: ch3 = 8'h10, `en[3]` = 1 with `ld_we`, `ld_sel` = 3, `ld_data` = 8'hA5.
  - Required: ch3 = 8'hA5 next cycle.
  - Then `clr_all` with `ld_we`, `ld_sel` = 3: ch3 = 0 and all `ovf` = 0.
- Read port: counts 5/6/7/8 in ch0..3; sweep `rd_sel` 0..5.
  - Required: `rd_data` = 5, 6, 7, 8, 0, 0, each one cycle after its select.
  - `ld_sel` = 6 with `ld_we` changes nothing.
- Async reset mid-operation: drop `rst_n` between edges while all channels count.
  - Required: all outputs 0 before the next edge, and counting resumes from 0.
